// File: rtl/seq_detect_pkg.sv
// Shared constants and types for the serial pattern detector.
// Patterns are written oldest bit first (MSB is received first).
package seq_detect_pkg;

    localparam int unsigned SEQ_LEN = 4;

    typedef logic [SEQ_LEN-1:0] pat_t;

    localparam pat_t SEQ_PAT_HI = 4'b1100;
    localparam pat_t SEQ_PAT_LO = 4'b1101;

endpackage

// File: rtl/shift_hist.sv
// History shift register (newest bit in the LSB) with a saturating fill counter.
// full rises once WIDTH bits have been clocked in since the last reset.
module shift_hist #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    output logic [WIDTH-1:0] hist,
    output logic             full
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

    logic [WIDTH-1:0] hist_q, hist_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // WIDTH must be at least 2 for the shift slice below.
    always_comb begin
        hist_d = {hist_q[WIDTH-2:0], x};
        cnt_d  = cnt_q;
        if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hist = hist_q;
    assign full = (cnt_q == CntMax);

endmodule

// File: rtl/seq_detect_core.sv
// Mealy detector for one of two LEN-bit patterns chosen by btn; overlapping matches allowed.
// z depends on the current x and btn, so it is valid before the edge that absorbs x.
module seq_detect_core
    import seq_detect_pkg::*;
#(
    parameter int unsigned       LEN    = SEQ_LEN,
    parameter logic [LEN-1:0]    PAT_HI = SEQ_PAT_HI,
    parameter logic [LEN-1:0]    PAT_LO = SEQ_PAT_LO
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic x,
    output logic z
);

    logic [LEN-2:0] hist;
    logic           full;
    logic [LEN-1:0] cand;
    logic [LEN-1:0] pat_sel;

    shift_hist #(
        .WIDTH (LEN - 1)
    ) u_shift_hist (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .hist (hist),
        .full (full)
    );

    always_comb begin
        cand    = {hist, x};
        pat_sel = btn ? PAT_HI : PAT_LO;
        // Gated by full so a zero-filled history never completes a pattern.
        z       = full && (cand == pat_sel) && !rst;
    end

endmodule

// File: tb/tb_seq_detect_core.sv
// Directed bench for seq_detect_core: a queue-based model plus literal expectations,
// compared on every falling edge.
module tb_seq_detect_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic x   = 1'b1;
    logic z;

    int n_vec = 0;
    int n_bad = 0;

    // Expected literal for the current vector: 0/1, or -1 when only the model applies.
    int  cur_lit = -1;
    bit  active  = 1'b0;
    bit  done    = 1'b0;

    // Bits clocked in since the last reset, oldest first, at most 3 kept.
    bit  seen[$];

    seq_detect_core dut (
        .clk (clk),
        .rst (rst),
        .btn (btn),
        .x   (x),
        .z   (z)
    );

    always #5 clk = ~clk;

    function automatic bit model_z(input bit r, input bit b, input bit xb);
        int w;
        int pat;
        if (r) return 1'b0;
        if (seen.size() < 3) return 1'b0;
        w = 0;
        foreach (seen[i]) w = w * 2 + int'(seen[i]);
        w   = w * 2 + int'(xb);
        pat = b ? 12 : 13;  // 1100 in HI mode, 1101 in LO mode
        return (w == pat);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            seen.delete();
        end else begin
            seen.push_back(x);
            if (seen.size() > 3) void'(seen.pop_front());
        end
    end

    always @(negedge clk) begin
        bit m;
        if (active && !done) begin
            m = model_z(rst, btn, x);
            n_vec++;
            if (z !== m) begin
                n_bad++;
                $display("FAIL model t=%0t rst=%0b btn=%0b x=%0b: z=%b, expected %0b",
                         $time, rst, btn, x, z, m);
            end
            if (cur_lit >= 0) begin
                n_vec++;
                if (z !== 1'(cur_lit)) begin
                    n_bad++;
                    $display("FAIL literal t=%0t rst=%0b btn=%0b x=%0b: z=%b, expected %0d",
                             $time, rst, btn, x, z, cur_lit);
                end
            end
        end
    end

    task automatic apply(input bit r, input bit b, input bit xb, input int lit);
        rst     = r;
        btn     = b;
        x       = xb;
        cur_lit = lit;
        active  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_bits(input bit b, input bit bits[], input int lits[]);
        foreach (bits[i]) apply(1'b0, b, bits[i], lits[i]);
    endtask

    initial begin
        // Reset held two cycles with a would-be matching input.
        apply(1'b1, 1'b1, 1'b1, 0);
        apply(1'b1, 1'b1, 1'b1, 0);
        apply(1'b0, 1'b1, 1'b1, 0);
        apply(1'b1, 1'b1, 1'b0, 0);

        // HI mode match, then LO mode continuing on the kept history.
        run_bits(1'b1, '{1, 1, 0, 0, 1, 0}, '{0, 0, 0, 1, 0, 0});
        run_bits(1'b0, '{1, 1, 0, 1, 1, 0}, '{0, 0, 0, 1, 0, 0});

        // Overlapping LO matches on bits 4 and 7.
        apply(1'b1, 1'b0, 1'b0, 0);
        run_bits(1'b0, '{1, 1, 0, 1, 1, 0, 1}, '{0, 0, 0, 1, 0, 0, 1});

        // Mode switch on the completing bit, both directions.
        apply(1'b1, 1'b1, 1'b0, 0);
        run_bits(1'b1, '{1, 1, 0}, '{0, 0, 0});
        apply(1'b0, 1'b0, 1'b1, 1);
        apply(1'b1, 1'b0, 1'b0, 0);
        run_bits(1'b0, '{1, 1, 0}, '{0, 0, 0});
        apply(1'b0, 1'b1, 1'b0, 1);

        // Reset mid-pattern: input on the reset cycle would otherwise complete 1100.
        apply(1'b1, 1'b1, 1'b0, 0);
        run_bits(1'b1, '{1, 1, 0}, '{0, 0, 0});
        apply(1'b1, 1'b1, 1'b0, 0);
        run_bits(1'b1, '{0, 1, 1, 0, 0}, '{0, 0, 0, 0, 1});

        // Completing bit of the wrong mode must not match.
        run_bits(1'b1, '{1, 1, 0}, '{0, 0, 0});
        apply(1'b0, 1'b0, 1'b0, 0);
        run_bits(1'b0, '{1, 1, 0}, '{0, 0, 0});
        apply(1'b0, 1'b1, 1'b1, 0);

        // Pseudo-random stretch checked against the model only.
        for (int i = 0; i < 200; i++) begin
            apply((($urandom_range(0, 29)) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), -1);
        end

        done = 1'b1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
